// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that lets NUM_CH requesters share one single-port memory.
// Requests are sampled on one edge. The winner's access is presented to the
// memory from registers in the following cycle. Read returns are steered back
// to the issuing channel after the memory's fixed read latency.
//
// Parameters
//   NUM_CH  number of requester channels (1..8)
//   ADDR_W  address width
//   DATA_W  data width
//   RD_LAT  cycles from mem_en to valid mem_dout (1..4)
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   req/we               per-channel request and write enable
//   addr/wdata           per-channel address and write data, channel i packed
//                        at [i*W +: W]
//   gnt                  one-hot, one-cycle grant pulse
//   rvalid/rdata         one-hot read-return pulse and shared read data
//   mem_en/mem_we        memory strobe and write enable
//   mem_addr/mem_din     memory address and write data
//   mem_dout             memory read data, valid RD_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout
);

  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [RD_LAT-1:0] pv_q;
  logic [ID_W-1:0]   pid_q [RD_LAT];
  logic [NUM_CH-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   idx;

  // Arbitration: a channel granted this cycle is masked so its still-held
  // request cannot be granted twice.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    ptr_d      = ptr_q;
    mem_en_d   = found;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    id_d       = id_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      ptr_d      = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
      mem_we_d   = we[win];
      mem_addr_d = addr[int'(win)*ADDR_W +: ADDR_W];
      mem_din_d  = wdata[int'(win)*DATA_W +: DATA_W];
      id_d       = win;
    end
  end

  // Read return: the tail of the latency pipeline lines up with valid
  // mem_dout, so data is captured there and presented one cycle later.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pv_q[RD_LAT-1]) begin
      rvalid_d = NUM_CH'(1) << pid_q[RD_LAT-1];
      rdata_d  = mem_dout;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q      <= '0;
      ptr_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      id_q       <= '0;
      pv_q       <= '0;
      for (int k = 0; k < RD_LAT; k++) pid_q[k] <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      id_q       <= id_d;
      // Entry pushed while the access is on the memory bus; writes push invalid.
      pv_q[0]    <= mem_en_q & ~mem_we_q;
      pid_q[0]   <= id_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k]  <= pv_q[k-1];
        pid_q[k] <= pid_q[k-1];
      end
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt      = gnt_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Instance A: 2 channels, RD_LAT=1, with a
// small RAM. Group B: 4 channels at RD_LAT=1..4 sharing stimulus, each with a
// latency-matched read-only memory. Instance C: single channel, RD_LAT=1.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: NUM_CH=2, RD_LAT=1 ----------------
  logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
  logic [31:0] a_addr;
  logic [15:0] a_wdata;
  logic [7:0]  a_rdata, a_mem_din, a_mem_dout;
  logic        a_mem_en, a_mem_we;
  logic [15:0] a_mem_addr;
  logic [7:0]  amem [256];

  mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u_a (
    .clk(clk), .resetn(resetn), .req(a_req), .we(a_we), .addr(a_addr),
    .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_din(a_mem_din), .mem_dout(a_mem_dout)
  );

  always @(posedge clk) begin
    if (!resetn) begin
      amem[8'h34] <= 8'hA5;
      amem[8'h77] <= 8'h3C;
    end else if (a_mem_en) begin
      if (a_mem_we) amem[a_mem_addr[7:0]] <= a_mem_din;
      else          a_mem_dout <= amem[a_mem_addr[7:0]];
    end
  end

  // ---------------- group B: NUM_CH=4, RD_LAT=g+1 ----------------
  logic [3:0]  b_req, b_we;
  logic [63:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_gnt [4];
  logic [3:0]  b_rvalid [4];
  logic [7:0]  b_rdata [4];
  logic        b_mem_en [4];
  logic        b_mem_we [4];
  logic [15:0] b_mem_addr [4];
  logic [7:0]  b_mem_din [4];
  logic [7:0]  b_mem_dout [4];

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [7:0] dq [4];
    mem_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(g + 1)) u_b (
      .clk(clk), .resetn(resetn), .req(b_req), .we(b_we), .addr(b_addr),
      .wdata(b_wdata), .gnt(b_gnt[g]), .rvalid(b_rvalid[g]), .rdata(b_rdata[g]),
      .mem_en(b_mem_en[g]), .mem_we(b_mem_we[g]), .mem_addr(b_mem_addr[g]),
      .mem_din(b_mem_din[g]), .mem_dout(b_mem_dout[g])
    );
    // Memory content is addr[7:0]^C3, delivered g+1 cycles after the address.
    always @(posedge clk) begin
      dq[0] <= b_mem_addr[g][7:0] ^ 8'hC3;
      for (int k = 1; k < 4; k++) dq[k] <= dq[k-1];
    end
    assign b_mem_dout[g] = dq[g];
  end

  // ---------------- instance C: NUM_CH=1, RD_LAT=1 ----------------
  logic        c_req, c_we, c_gnt, c_rvalid, c_mem_en, c_mem_we;
  logic [15:0] c_addr, c_mem_addr;
  logic [7:0]  c_wdata, c_rdata, c_mem_din, c_mem_dout;

  mem_arbiter #(.NUM_CH(1), .ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u_c (
    .clk(clk), .resetn(resetn), .req(c_req), .we(c_we), .addr(c_addr),
    .wdata(c_wdata), .gnt(c_gnt), .rvalid(c_rvalid), .rdata(c_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_din(c_mem_din), .mem_dout(c_mem_dout)
  );

  always @(posedge clk) c_mem_dout <= c_mem_addr[7:0] + 8'h01;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_rv;
    int         i;

    resetn = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (3) step();

    // Reset state
    chk("rst_a_gnt", a_gnt, 2'b00);
    chk("rst_a_rvalid", a_rvalid, 2'b00);
    chk("rst_a_mem_en", a_mem_en, 1'b0);
    chk("rst_a_mem_we", a_mem_we, 1'b0);
    chk("rst_a_mem_addr", a_mem_addr, 16'h0);
    chk("rst_a_mem_din", a_mem_din, 8'h0);
    chk("rst_a_rdata", a_rdata, 8'h0);
    chk("rst_b_gnt", b_gnt[3], 4'h0);
    chk("rst_c_mem_en", c_mem_en, 1'b0);

    // Contention straight out of reset: ch0 reads 0x1234, ch1 reads 0x0377
    a_addr = {16'h0377, 16'h1234};
    a_req  = 2'b11;
    resetn = 1'b1;
    step();
    chk("cont1_gnt", a_gnt, 2'b01);
    chk("cont1_en", a_mem_en, 1'b1);
    chk("cont1_addr", a_mem_addr, 16'h1234);
    step();
    chk("cont2_gnt", a_gnt, 2'b10);
    chk("cont2_en", a_mem_en, 1'b1);
    chk("cont2_addr", a_mem_addr, 16'h0377);
    step();
    chk("cont3_gnt", a_gnt, 2'b01);
    chk("cont3_en", a_mem_en, 1'b1);
    chk("cont3_rvalid", a_rvalid, 2'b01);
    chk("cont3_rdata", a_rdata, 8'hA5);
    step();
    chk("cont4_gnt", a_gnt, 2'b10);
    chk("cont4_en", a_mem_en, 1'b1);
    chk("cont4_rvalid", a_rvalid, 2'b10);
    chk("cont4_rdata", a_rdata, 8'h3C);
    a_req = 2'b00;
    step();
    chk("cont5_gnt", a_gnt, 2'b00);
    chk("cont5_en", a_mem_en, 1'b0);
    chk("cont5_addr_hold", a_mem_addr, 16'h0377);
    chk("cont5_rvalid", a_rvalid, 2'b01);
    chk("cont5_rdata", a_rdata, 8'hA5);
    step();
    chk("cont6_rvalid", a_rvalid, 2'b10);
    chk("cont6_rdata", a_rdata, 8'h3C);

    // Single read: ch0 reads 0x1234 -> 0xA5
    a_req = 2'b01;
    step();
    chk("rd_gnt", a_gnt, 2'b01);
    chk("rd_en", a_mem_en, 1'b1);
    chk("rd_we", a_mem_we, 1'b0);
    chk("rd_addr", a_mem_addr, 16'h1234);
    a_req = 2'b00;
    step();
    chk("rd_gnt_off", a_gnt, 2'b00);
    chk("rd_en_off", a_mem_en, 1'b0);
    chk("rd_rvalid_early", a_rvalid, 2'b00);
    step();
    chk("rd_rvalid", a_rvalid, 2'b01);
    chk("rd_rdata", a_rdata, 8'hA5);
    step();
    chk("rd_rvalid_pulse", a_rvalid, 2'b00);
    chk("rd_rdata_hold", a_rdata, 8'hA5);

    // Write then read on ch1 at 0x0200
    a_req = 2'b10; a_we = 2'b10;
    a_addr[31:16] = 16'h0200; a_wdata[15:8] = 8'h5A;
    step();
    chk("wr_gnt", a_gnt, 2'b10);
    chk("wr_en", a_mem_en, 1'b1);
    chk("wr_we", a_mem_we, 1'b1);
    chk("wr_addr", a_mem_addr, 16'h0200);
    chk("wr_din", a_mem_din, 8'h5A);
    a_we = 2'b00;
    step();
    chk("wr_mask_gnt", a_gnt, 2'b00);
    chk("wr_mask_en", a_mem_en, 1'b0);
    chk("wr_we_hold", a_mem_we, 1'b1);
    step();
    chk("wrrd_gnt", a_gnt, 2'b10);
    chk("wrrd_we", a_mem_we, 1'b0);
    chk("wrrd_addr", a_mem_addr, 16'h0200);
    chk("wr_no_rvalid", a_rvalid, 2'b00);
    a_req = 2'b00;
    step();
    chk("wrrd_rvalid_early", a_rvalid, 2'b00);
    step();
    chk("wrrd_rvalid", a_rvalid, 2'b10);
    chk("wrrd_rdata", a_rdata, 8'h5A);

    // Single channel: one-cycle pulse, then held request, then withdrawal
    c_addr = 16'h0042; c_req = 1'b1;
    step();
    chk("c_pulse_gnt", c_gnt, 1'b1);
    chk("c_pulse_en", c_mem_en, 1'b1);
    chk("c_pulse_addr", c_mem_addr, 16'h0042);
    c_req = 1'b0;
    step();
    chk("c_drop_gnt", c_gnt, 1'b0);
    chk("c_drop_en", c_mem_en, 1'b0);
    step();
    chk("c_rvalid", c_rvalid, 1'b1);
    chk("c_rdata", c_rdata, 8'h43);
    c_req = 1'b1;
    step();
    chk("c_hold1_gnt", c_gnt, 1'b1);
    step();
    chk("c_hold2_gnt", c_gnt, 1'b0);
    step();
    chk("c_hold3_gnt", c_gnt, 1'b1);
    step();
    chk("c_hold4_gnt", c_gnt, 1'b0);
    c_req = 1'b0;
    step();
    chk("c_withdraw_gnt", c_gnt, 1'b0);
    chk("c_withdraw_en", c_mem_en, 1'b0);

    // Latency sweep: four back-to-back reads, channel i at 0xA0B0+i
    for (int ch = 0; ch < 4; ch++) b_addr[ch*16 +: 16] = 16'hA0B0 + 16'(ch);
    b_req = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sw_gnt", b_gnt[0], (k <= 4) ? (4'b0001 << (k - 1)) : 4'b0000);
      if (k <= 4) b_req[k-1] = 1'b0;
      for (int g = 0; g < 4; g++) begin
        i = k - 3 - g;
        exp_rv = (i >= 0 && i < 4) ? (4'b0001 << i) : 4'b0000;
        chk("sw_rvalid", b_rvalid[g], exp_rv);
        if (i >= 0 && i < 4) chk("sw_rdata", b_rdata[g], (8'hB0 + 8'(i)) ^ 8'hC3);
      end
    end

    // Reset one cycle after a read issue on RD_LAT=3
    b_addr[15:0] = 16'h1111;
    b_req = 4'b0001;
    step();
    chk("rr_gnt", b_gnt[2], 4'b0001);
    chk("rr_en", b_mem_en[2], 1'b1);
    b_req = 4'b0000;
    step();
    chk("rr_rvalid_pre", b_rvalid[2], 4'b0000);
    resetn = 1'b0;
    #1;
    chk("rr_gnt0", b_gnt[2], 4'b0000);
    chk("rr_rvalid0", b_rvalid[2], 4'b0000);
    chk("rr_en0", b_mem_en[2], 1'b0);
    chk("rr_we0", b_mem_we[2], 1'b0);
    chk("rr_addr0", b_mem_addr[2], 16'h0);
    chk("rr_din0", b_mem_din[2], 8'h0);
    chk("rr_rdata0", b_rdata[2], 8'h0);
    chk("rr_a_addr0", a_mem_addr, 16'h0);
    step();
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_no_rvalid", b_rvalid[2], 4'b0000);
      chk("rr_no_en", b_mem_en[2], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels, legal range 1..8.
REQ-002 Parameter ADDR_W, default 16, address width.
REQ-003 Parameter DATA_W, default 8, data width.
REQ-004 Parameter RD_LAT, default 1, memory read latency in cycles from mem_en to valid mem_dout, legal range 1..4.
REQ-005 Port clk  in  1  single clock; all logic rising-edge.
REQ-006 Port resetn  in  1  reset; asynchronous, active-low.
REQ-007 Port req  in  NUM_CH  per-channel access request, held until gnt.
REQ-008 Port we  in  NUM_CH  per-channel write enable; 1 = write, 0 = read.
REQ-009 Port addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 Port wdata  in  NUM_CH*DATA_W  per-channel write data, packed the same way as addr.
REQ-011 Port gnt  out  NUM_CH  one-hot grant pulse, one cycle.
REQ-012 Port rvalid  out  NUM_CH  one-hot read-return pulse, one cycle.
REQ-013 Port rdata  out  DATA_W  read data, shared by all channels; qualified by rvalid.
REQ-014 Port mem_en  out  1  memory access strobe.
REQ-015 Port mem_we  out  1  memory write enable, qualified by mem_en.
REQ-016 Port mem_addr  out  ADDR_W  memory address.
REQ-017 Port mem_din  out  DATA_W  memory write data.
REQ-018 Port mem_dout  in  DATA_W  memory read data.

Function
REQ-019 The arbiter SHALL sample req in cycle t and SHALL drive gnt, mem_en, mem_we, mem_addr and mem_din from registers in cycle t+1, using the winner's we/addr/wdata sampled at t.
REQ-020 The arbiter SHALL issue at most one access per cycle and SHALL sustain one access per cycle when two or more channels request.
REQ-021 A channel whose gnt is high in cycle t SHALL be masked from arbitration in cycle t, so a held req is never double-granted.
REQ-022 The winner SHALL be the first unmasked requesting channel at or after the round-robin pointer, searching upward modulo NUM_CH.
REQ-023 After a grant to channel i, the pointer SHALL become (i+1) mod NUM_CH; with no grant the pointer SHALL hold.
REQ-024 With no unmasked request, gnt SHALL be all-zero and mem_en SHALL be 0; mem_addr, mem_din and mem_we SHALL hold their last values.
REQ-025 Each read issue SHALL push {valid, channel id} into an RD_LAT-deep shift pipeline; write issues SHALL push an invalid entry.
REQ-026 When a valid entry exits the pipeline in cycle c+RD_LAT (issue cycle c), the block SHALL capture mem_dout in that cycle.
REQ-027 In cycle c+RD_LAT+1 the block SHALL drive rdata with the captured value and pulse rvalid[id] for one cycle.
REQ-028 Back-to-back reads SHALL return in issue order, one per cycle, with no loss.
REQ-029 rdata SHALL hold its last value when no rvalid is asserted.
REQ-030 With NUM_CH=1 the pointer SHALL stay at 0, and the single channel SHALL receive grants no more than every other cycle.
REQ-031 req deasserted before grant SHALL be treated as withdrawn, with no access issued for that channel.

Reset
REQ-032 While resetn=0, gnt, rvalid, mem_en and mem_we SHALL be 0; mem_addr, mem_din and rdata SHALL be all-zero; the pointer SHALL be 0; all pipeline entries SHALL be invalid.
REQ-033 Reset asserted with reads in flight SHALL discard them, and no rvalid SHALL appear after release for pre-reset accesses.
REQ-034 The first arbitration SHALL occur on the first rising edge after resetn deasserts.

Verification
REQ-035 Single read: NUM_CH=2, RD_LAT=1; ch0 read addr 0x1234, mem returns 0xA5 -> gnt[0] at t+1, mem_addr=0x1234, rvalid[0] and rdata=0xA5 at t+3.
REQ-036 Contention: ch0 and ch1 request continuously from reset -> grants alternate 0,1,0,1 with mem_en high every cycle.
REQ-037 Write then read: ch1 writes 0x5A to 0x0200, then reads 0x0200 -> mem_we=1 with mem_din=0x5A, then rvalid[1] with rdata=0x5A; rvalid never pulses for the write.
REQ-038 Latency sweep: RD_LAT=1..4, four back-to-back reads across NUM_CH=4 -> each rvalid[id] arrives at issue+RD_LAT+1, in order, with the correct data.
REQ-039 Reset mid-read: RD_LAT=3, resetn low one cycle after the read issue -> all outputs zero, and no rvalid after release.
REQ-040 Withdrawal: NUM_CH=1, req pulsed one cycle then dropped -> gnt still issues at t+1 only if req was high at t; a held req is granted every other cycle.
